// File: rtl/tx_byte_arbiter.sv
// tx_byte_arbiter: shares one Private-Read byte port among NumReq TX byte sources, grant locked per transfer.
// Build option TX_ARB_FIXED_PRIO_EN: fixed priority (requester 0 highest) instead of round-robin.
module tx_byte_arbiter #(
    parameter int NumReq    = 2,
    parameter int DataWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq*DataWidth-1:0]   req_byte_i,
    input  logic [NumReq-1:0]             req_last_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq-1:0]             req_err_o,
    output logic [DataWidth-1:0]          tx_byte_o,
    output logic                          tx_byte_last_o,
    output logic                          tx_byte_valid_o,
    input  logic                          tx_byte_ready_i,
    input  logic                          tx_byte_err_i,
    input  logic                          xfer_end_i,
    output logic [NumReq-1:0]             grant_o,
    output logic                          busy_o
);
    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                 state, state_nxt;
    logic [NumReq-1:0]      grant, grant_nxt, pick;
    logic [PtrW-1:0]        rr_ptr, rr_ptr_nxt, gnt_idx;
    logic                   pick_found, release_now, g_valid, g_last;
    logic [DataWidth-1:0]   g_byte;

    // first valid at or above rr_ptr, otherwise first valid below it
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (k >= int'(rr_ptr))) begin
                pick       = '0;
                pick[k]    = 1'b1;
                pick_found = 1'b1;
            end
        end
        if (!pick_found) begin
            for (int k = NumReq - 1; k >= 0; k--) begin
                if (req_valid_i[k]) begin
                    pick       = '0;
                    pick[k]    = 1'b1;
                    pick_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_byte  = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (grant[k]) begin
                gnt_idx = PtrW'(k);
                g_valid = req_valid_i[k];
                g_last  = req_last_i[k];
                g_byte  = req_byte_i[k*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        rr_ptr_nxt      = rr_ptr;
        tx_byte_o       = '0;
        tx_byte_last_o  = 1'b0;
        tx_byte_valid_o = 1'b0;
        req_ready_o     = '0;
        req_err_o       = '0;
        busy_o          = 1'b0;
        release_now     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick;
                end
            end
            LOCKED: begin
                busy_o          = 1'b1;
                tx_byte_o       = g_byte;
                tx_byte_last_o  = g_last;
                tx_byte_valid_o = g_valid;
                req_ready_o     = grant & {NumReq{tx_byte_ready_i & g_valid}};
                req_err_o       = grant & {NumReq{tx_byte_err_i}};
                release_now     = (g_valid & tx_byte_ready_i & g_last) | tx_byte_err_i | xfer_end_i;
                if (release_now) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
`ifdef TX_ARB_FIXED_PRIO_EN
                    rr_ptr_nxt = '0;
`else
                    rr_ptr_nxt = (gnt_idx == LastIdx) ? '0 : gnt_idx + PtrW'(1);
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o = grant;

endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Self-checking bench for tx_byte_arbiter: queue-driven byte sources and a byte scoreboard.
module tb_tx_byte_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] req_byte_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_err_o;
    logic [7:0]  tx_byte_o;
    logic        tx_byte_last_o;
    logic        tx_byte_valid_o;
    logic        tx_byte_ready_i;
    logic        tx_byte_err_i;
    logic        xfer_end_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [8:0]  src0[$];
    logic [8:0]  src1[$];
    logic [1:0]  src_en;
    logic [10:0] exp_q[$];
    logic [10:0] exp_e;

    always #5 clk_i = ~clk_i;

    tx_byte_arbiter #(.NumReq(2), .DataWidth(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_byte_i(req_byte_i), .req_last_i(req_last_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .req_err_o(req_err_o),
        .tx_byte_o(tx_byte_o), .tx_byte_last_o(tx_byte_last_o), .tx_byte_valid_o(tx_byte_valid_o),
        .tx_byte_ready_i(tx_byte_ready_i), .tx_byte_err_i(tx_byte_err_i), .xfer_end_i(xfer_end_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic drive_src();
        req_valid_i[0]  = src_en[0] && (src0.size() > 0);
        req_last_i[0]   = (src0.size() > 0) ? src0[0][8] : 1'b0;
        req_byte_i[7:0] = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
        req_valid_i[1]  = src_en[1] && (src1.size() > 0);
        req_last_i[1]   = (src1.size() > 0) ? src1[0][8] : 1'b0;
        req_byte_i[15:8] = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
    endtask

    // called at a falling edge; sources consume accepted bytes and abandon aborted transfers
    task automatic cycle(input logic e, input logic x, input logic r);
        logic [1:0] rdy, ev, gs;
        logic       xs;
        rdy = req_ready_o;
        ev  = req_err_o;
        gs  = grant_o;
        xs  = xfer_end_i;
        @(posedge clk_i);
        #1;
        if (rdy[0] && src0.size() > 0) void'(src0.pop_front());
        if (rdy[1] && src1.size() > 0) void'(src1.pop_front());
        if (ev[0] || (xs && gs[0])) src0.delete();
        if (ev[1] || (xs && gs[1])) src1.delete();
        tx_byte_err_i   = e;
        xfer_end_i      = x;
        tx_byte_ready_i = r;
        drive_src();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        src_en = 2'b11;
        tx_byte_ready_i = 1'b1;
        tx_byte_err_i = 1'b0;
        xfer_end_i = 1'b0;
        src0.push_back(9'h1AA);
        src1.push_back(9'h1BB);
        drive_src();
        repeat (2) @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_grant grant=%b busy=%b exp 00/0", grant_o, busy_o);
        end
        checks++;
        if (tx_byte_valid_o !== 1'b0 || tx_byte_last_o !== 1'b0 || tx_byte_o !== 8'h00) begin
            errors++; $display("FAIL reset_byte v=%b l=%b b=%h exp 0/0/00", tx_byte_valid_o, tx_byte_last_o, tx_byte_o);
        end
        checks++;
        if (req_ready_o !== 2'b00 || req_err_o !== 2'b00) begin
            errors++; $display("FAIL reset_req ready=%b err=%b exp 00/00", req_ready_o, req_err_o);
        end
        src0.delete();
        src1.delete();
        drive_src();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        src0.push_back(9'h0A1); src0.push_back(9'h0A2); src0.push_back(9'h1A3);
        exp_q.push_back({2'b01, 9'h0A1}); exp_q.push_back({2'b01, 9'h0A2}); exp_q.push_back({2'b01, 9'h1A3});
        drive_src();
        #1;
        for (int c = 0; c < 6; c++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL single_sb_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL single_sb got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            if (c == 0) begin
                checks++;
                if (grant_o !== 2'b00 || tx_byte_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin
                    errors++; $display("FAIL single_latency grant=%b v=%b rdy=%b exp 00/0/00", grant_o, tx_byte_valid_o, req_ready_o);
                end
            end
            if (c == 1) begin
                checks++;
                if (grant_o !== 2'b01 || busy_o !== 1'b1) begin
                    errors++; $display("FAIL single_grant grant=%b busy=%b exp 01/1", grant_o, busy_o);
                end
            end
            if (c == 4) begin
                checks++;
                if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
                    errors++; $display("FAIL single_release grant=%b busy=%b exp 00/0", grant_o, busy_o);
                end
            end
            cycle(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL single_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic prev_last;
        prev_last = 1'b0;
        src0.push_back(9'h1B0); src0.push_back(9'h1B1);
        src1.push_back(9'h1C0); src1.push_back(9'h1C1);
`ifdef TX_ARB_FIXED_PRIO_EN
        exp_q.push_back({2'b01, 9'h1B0}); exp_q.push_back({2'b01, 9'h1B1});
        exp_q.push_back({2'b10, 9'h1C0}); exp_q.push_back({2'b10, 9'h1C1});
`else
        exp_q.push_back({2'b10, 9'h1C0}); exp_q.push_back({2'b01, 9'h1B0});
        exp_q.push_back({2'b10, 9'h1C1}); exp_q.push_back({2'b01, 9'h1B1});
`endif
        drive_src();
        #1;
        for (int c = 0; c < 10; c++) begin
            if (prev_last) begin
                checks++;
                if (grant_o !== 2'b00 || tx_byte_valid_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_gap cyc=%0d grant=%b v=%b exp 00/0", c, grant_o, tx_byte_valid_o);
                end
            end
            prev_last = 1'b0;
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                prev_last = tx_byte_last_o;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_sb_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL b2b_sb got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            cycle(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_error();
        src1.push_back(9'h0D0); src1.push_back(9'h0D1); src1.push_back(9'h1D2);
        exp_q.push_back({2'b10, 9'h0D0}); exp_q.push_back({2'b10, 9'h0D1}); exp_q.push_back({2'b01, 9'h1E0});
        drive_src();
        #1;
        for (int c = 0; c < 6; c++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL err_sb_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL err_sb got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            if (c == 1) begin
                checks++;
                if (grant_o !== 2'b10) begin
                    errors++; $display("FAIL err_grant grant=%b exp 10", grant_o);
                end
                src0.push_back(9'h1E0);
            end
            if (c == 2) begin
                checks++;
                if (req_err_o !== 2'b10 || req_ready_o !== 2'b10) begin
                    errors++; $display("FAIL err_pulse err=%b rdy=%b exp 10/10", req_err_o, req_ready_o);
                end
            end else begin
                checks++;
                if (req_err_o !== 2'b00) begin
                    errors++; $display("FAIL err_quiet cyc=%0d err=%b exp 00", c, req_err_o);
                end
            end
            if (c == 3) begin
                checks++;
                if (grant_o !== 2'b00 || busy_o !== 1'b0) begin
                    errors++; $display("FAIL err_release grant=%b busy=%b exp 00/0", grant_o, busy_o);
                end
            end
            cycle(c == 1, 1'b0, 1'b1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL err_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_xfer_end();
        src0.push_back(9'h0F0); src0.push_back(9'h0F1); src0.push_back(9'h0F2); src0.push_back(9'h1F3);
        exp_q.push_back({2'b01, 9'h0F0});
        drive_src();
        #1;
        for (int c = 0; c < 9; c++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL xend_sb_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL xend_sb got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            if (c == 2) begin
                checks++;
                if (grant_o !== 2'b01 || req_err_o !== 2'b00) begin
                    errors++; $display("FAIL xend_locked grant=%b err=%b exp 01/00", grant_o, req_err_o);
                end
            end
            if (c == 3) begin
                checks++;
                if (grant_o !== 2'b00 || busy_o !== 1'b0 || req_err_o !== 2'b00) begin
                    errors++; $display("FAIL xend_release grant=%b busy=%b err=%b exp 00/0/00", grant_o, busy_o, req_err_o);
                end
                src0.push_back(9'h1A0);
                src1.push_back(9'h1C5);
`ifdef TX_ARB_FIXED_PRIO_EN
                exp_q.push_back({2'b01, 9'h1A0}); exp_q.push_back({2'b10, 9'h1C5});
`else
                exp_q.push_back({2'b10, 9'h1C5}); exp_q.push_back({2'b01, 9'h1A0});
`endif
            end
            cycle(1'b0, c == 1, c != 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL xend_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stall();
        src0.push_back(9'h055); src0.push_back(9'h156);
        exp_q.push_back({2'b01, 9'h055}); exp_q.push_back({2'b01, 9'h156}); exp_q.push_back({2'b10, 9'h177});
        drive_src();
        #1;
        for (int c = 0; c < 12; c++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_sb_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL stall_sb got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            if (c == 1) src1.push_back(9'h177);
            if (c >= 1 && c <= 5) begin
                checks++;
                if (grant_o !== 2'b01 || req_ready_o !== 2'b00 || tx_byte_valid_o !== logic'(c % 2 == 1)) begin
                    errors++; $display("FAIL stall_hold cyc=%0d grant=%b rdy=%b v=%b exp 01/00/%0d",
                                       c, grant_o, req_ready_o, tx_byte_valid_o, c % 2);
                end
            end
            src_en[0] = (c >= 5) || (c % 2 == 0);
            cycle(1'b0, 1'b0, c >= 5);
        end
        src_en = 2'b11;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL stall_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        src0.push_back(9'h160);
        exp_q.push_back({2'b01, 9'h160});
        exp_q.push_back({2'b10, 9'h080}); exp_q.push_back({2'b10, 9'h081});
        drive_src();
        #1;
        for (int c = 0; c < 6; c++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rmid_sb_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL rmid_sb got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            if (c == 2) begin
                src1.push_back(9'h080); src1.push_back(9'h081); src1.push_back(9'h082); src1.push_back(9'h183);
            end
            if (c == 5) begin
                rst_ni = 1'b0;
                #1;
                checks++;
                if (grant_o !== 2'b00 || busy_o !== 1'b0 || tx_byte_valid_o !== 1'b0 || tx_byte_o !== 8'h00 ||
                    tx_byte_last_o !== 1'b0 || req_ready_o !== 2'b00 || req_err_o !== 2'b00) begin
                    errors++; $display("FAIL rmid_async grant=%b busy=%b v=%b b=%h l=%b rdy=%b err=%b exp all 0",
                                       grant_o, busy_o, tx_byte_valid_o, tx_byte_o, tx_byte_last_o, req_ready_o, req_err_o);
                end
                src0.delete();
                src1.delete();
                drive_src();
                @(posedge clk_i);
                #1 rst_ni = 1'b1;
                @(negedge clk_i);
            end else begin
                cycle(1'b0, 1'b0, 1'b1);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rmid_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
        src0.push_back(9'h190);
        src1.push_back(9'h191);
        exp_q.push_back({2'b01, 9'h190}); exp_q.push_back({2'b10, 9'h191});
        drive_src();
        #1;
        for (int c = 0; c < 6; c++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rmid_rr_extra got %h exp none", {grant_o, tx_byte_last_o, tx_byte_o});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({grant_o, tx_byte_last_o, tx_byte_o} !== exp_e) begin
                        errors++; $display("FAIL rmid_rr got %h exp %h", {grant_o, tx_byte_last_o, tx_byte_o}, exp_e);
                    end
                end
            end
            cycle(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rmid_rr_drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_xfer_end();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
